// File: rtl/score_playback_sequencer_pkg.sv
// rtl/score_playback_sequencer_pkg.sv - shared state encoding and score ROM field layout
package score_playback_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_LOAD      = 3'd2,
        ST_PLAY      = 3'd3,
        ST_PAUSED    = 3'd4,
        ST_FINISHED  = 3'd5
    } seq_state_e;

    localparam int ROM_W    = 24;
    localparam int LEN_MSB  = 23;
    localparam int LEN_LSB  = 8;
    localparam int NOTE_MSB = 7;
    localparam int NOTE_LSB = 4;
    localparam int OCT_MSB  = 3;
    localparam int OCT_LSB  = 0;

    // A zero length entry terminates the score
    localparam logic [15:0] END_MARKER = 16'd0;

    function automatic logic [15:0] rom_len(input logic [ROM_W-1:0] entry);
        return entry[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [3:0] rom_note(input logic [ROM_W-1:0] entry);
        return entry[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [3:0] rom_oct(input logic [ROM_W-1:0] entry);
        return entry[OCT_MSB:OCT_LSB];
    endfunction

endpackage

// File: rtl/score_playback_sequencer_arbiter.sv
// rtl/score_playback_sequencer_arbiter.sv - score ROM port mux with low-priority preview reads
module score_rom_arbiter
    import score_playback_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_1ms,
    input  logic              rst,
    input  logic              load_cycle_i,
    input  logic [ADDR_W-1:0] note_pointer_i,
    input  logic              preview_req_i,
    input  logic [ADDR_W-1:0] preview_addr_i,
    input  logic [ROM_W-1:0]  rom_data_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [ROM_W-1:0]  preview_data_o,
    output logic              preview_valid_o
);

    logic              grant;
    logic [ROM_W-1:0]  preview_data_q, preview_data_d;
    logic              preview_valid_q;

    // Playback fetches in LOAD win outright; the requester simply keeps req high
    assign grant      = preview_req_i && !load_cycle_i;
    assign rom_addr_o = grant ? preview_addr_i : note_pointer_i;

    always_comb begin
        preview_data_d = preview_data_q;
        if (grant) begin
            preview_data_d = rom_data_i;
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            preview_data_q  <= '0;
            preview_valid_q <= 1'b0;
        end else begin
            preview_data_q  <= preview_data_d;
            preview_valid_q <= grant;
        end
    end

    assign preview_data_o  = preview_data_q;
    assign preview_valid_o = preview_valid_q;

endmodule

// File: rtl/score_playback_sequencer.sv
// rtl/score_playback_sequencer.sv - score playback transport FSM and ROM port owner
module score_playback_sequencer
    import score_playback_sequencer_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int COUNTDOWN_MS = 3000
) (
    input  logic              clk_1ms,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ROM_W-1:0]  rom_data,
    output logic [2:0]        state,
    output logic [ADDR_W-1:0] note_pointer,
    output logic [3:0]        cur_note,
    output logic [3:0]        cur_octave,
    output logic [15:0]       remaining,
    output logic [11:0]       countdown,
    output logic              note_on,
    output logic              song_done,
    input  logic              preview_req,
    input  logic [ADDR_W-1:0] preview_addr,
    output logic [ROM_W-1:0]  preview_data,
    output logic              preview_valid
);

    localparam logic [11:0] CD_START = 12'(COUNTDOWN_MS - 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [3:0]        note_q, note_d;
    logic [3:0]        oct_q, oct_d;
    logic [15:0]       rem_q, rem_d;
    logic [11:0]       cd_q, cd_d;
    logic              done_q, done_d;
    logic [15:0]       load_len;

    // In LOAD the arbiter guarantees rom_data is the entry at note_pointer
    assign load_len = rom_len(rom_data);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        note_d  = note_q;
        oct_d   = oct_q;
        rem_d   = rem_q;
        cd_d    = cd_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (play) begin
                        state_d = ST_COUNTDOWN;
                        cd_d    = CD_START;
                    end
                end
                ST_COUNTDOWN: begin
                    if (cd_q == 12'd0) begin
                        state_d = ST_LOAD;
                    end else begin
                        cd_d = cd_q - 12'd1;
                    end
                end
                ST_LOAD: begin
                    if (load_len == END_MARKER) begin
                        if (loop_en) begin
                            ptr_d = '0;
                        end else begin
                            state_d = ST_FINISHED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        note_d  = rom_note(rom_data);
                        oct_d   = rom_oct(rom_data);
                        rem_d   = load_len;
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // Pausing suppresses this cycle's decrement
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        rem_d = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            ptr_d   = ptr_q + ADDR_W'(1);
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (play || pause) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_FINISHED: begin
                    if (play) begin
                        state_d = ST_COUNTDOWN;
                        cd_d    = CD_START;
                        ptr_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            note_q  <= 4'd0;
            oct_q   <= 4'd0;
            rem_q   <= 16'd0;
            cd_q    <= 12'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            rem_q   <= rem_d;
            cd_q    <= cd_d;
            done_q  <= done_d;
        end
    end

    score_rom_arbiter #(
        .ADDR_W(ADDR_W)
    ) u_arbiter (
        .clk_1ms        (clk_1ms),
        .rst            (rst),
        .load_cycle_i   (state_q == ST_LOAD),
        .note_pointer_i (ptr_q),
        .preview_req_i  (preview_req),
        .preview_addr_i (preview_addr),
        .rom_data_i     (rom_data),
        .rom_addr_o     (rom_addr),
        .preview_data_o (preview_data),
        .preview_valid_o(preview_valid)
    );

    assign state        = state_q;
    assign note_pointer = ptr_q;
    assign cur_note     = note_q;
    assign cur_octave   = oct_q;
    assign remaining    = rem_q;
    assign countdown    = cd_q;
    assign note_on      = (state_q == ST_PLAY) && (note_q != 4'd0);
    assign song_done    = done_q;

endmodule

// File: tb/tb_score_playback_sequencer.sv
// tb/tb_score_playback_sequencer.sv - self-checking bench for score_playback_sequencer
module tb_score_playback_sequencer;

    localparam int AW = 8;
    localparam int CD = 5;

    logic          clk_1ms = 1'b0;
    logic          rst, play, pause, stop, loop_en, preview_req;
    logic [AW-1:0] preview_addr, rom_addr, note_pointer;
    logic [23:0]   rom_data, preview_data;
    logic [2:0]    state;
    logic [3:0]    cur_note, cur_octave;
    logic [15:0]   remaining;
    logic [11:0]   countdown;
    logic          note_on, song_done, preview_valid;

    logic [23:0]   rom [0:255];
    assign rom_data = rom[rom_addr];

    always #5 clk_1ms = ~clk_1ms;

    score_playback_sequencer #(.ADDR_W(AW), .COUNTDOWN_MS(CD)) dut (
        .clk_1ms(clk_1ms), .rst(rst), .play(play), .pause(pause), .stop(stop),
        .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data), .state(state),
        .note_pointer(note_pointer), .cur_note(cur_note), .cur_octave(cur_octave),
        .remaining(remaining), .countdown(countdown), .note_on(note_on),
        .song_done(song_done), .preview_req(preview_req), .preview_addr(preview_addr),
        .preview_data(preview_data), .preview_valid(preview_valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: transport state as named phases plus plain integers
    int          m_state, m_ptr, m_note, m_oct, m_rem, m_cd;
    bit          m_done, m_pv;
    logic [23:0] m_pdata;
    logic [AW-1:0] last_rom_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [23:0] e;
        if (rst) begin
            m_state = 0; m_ptr = 0; m_note = 0; m_oct = 0; m_rem = 0; m_cd = 0;
            m_done = 0; m_pv = 0; m_pdata = '0;
            return;
        end
        m_done = 0;
        m_pv   = preview_req && (m_state != 2);
        if (m_pv) m_pdata = rom[preview_addr];
        if (stop) begin
            m_state = 0; m_ptr = 0;
        end else begin
            case (m_state)
                0: if (play) begin m_state = 1; m_cd = CD - 1; end
                1: if (m_cd == 0) m_state = 2; else m_cd = m_cd - 1;
                2: begin
                    e = rom[m_ptr];
                    if (e[23:8] == 16'd0) begin
                        if (loop_en) m_ptr = 0;
                        else begin m_state = 5; m_done = 1; end
                    end else begin
                        m_note = int'(e[7:4]); m_oct = int'(e[3:0]);
                        m_rem = int'(e[23:8]); m_state = 3;
                    end
                end
                3: if (pause) m_state = 4;
                   else if (m_rem == 1) begin m_rem = 0; m_ptr = (m_ptr + 1) % 256; m_state = 2; end
                   else m_rem = m_rem - 1;
                4: if (play || pause) m_state = 3;
                5: if (play) begin m_state = 1; m_cd = CD - 1; m_ptr = 0; end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("state", 32'(state), 32'(m_state));
        chk("note_pointer", 32'(note_pointer), 32'(m_ptr));
        chk("cur_note", 32'(cur_note), 32'(m_note));
        chk("cur_octave", 32'(cur_octave), 32'(m_oct));
        chk("remaining", 32'(remaining), 32'(m_rem));
        chk("countdown", 32'(countdown), 32'(m_cd));
        chk("note_on", 32'(note_on), 32'(m_state == 3 && m_note != 0));
        chk("song_done", 32'(song_done), 32'(m_done));
        chk("preview_valid", 32'(preview_valid), 32'(m_pv));
        chk("preview_data", 32'(preview_data), 32'(m_pdata));
    endtask

    // One clock: drive at negedge, check the mux, advance model, check registers
    task automatic tick(input bit r, input bit pl, input bit pa, input bit st,
                        input bit lp, input bit pr, input int pad);
        int exp_addr;
        rst = r; play = pl; pause = pa; stop = st; loop_en = lp;
        preview_req = pr; preview_addr = pad[AW-1:0];
        #1;
        last_rom_addr = rom_addr;
        if (!r) begin
            exp_addr = (m_state != 2 && pr) ? pad : m_ptr;
            chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
        end
        model_step();
        @(negedge clk_1ms);
        compare_all();
    endtask

    task automatic play_to_load(input bit lp);
        tick(1, 0, 0, 0, lp, 0, 0);
        tick(0, 1, 0, 0, lp, 0, 0);
        for (int i = 0; i < CD; i++) tick(0, 0, 0, 0, lp, 0, 0);
    endtask

    typedef struct {
        bit rst, play, pause, stop, loop_en;
        logic [2:0] st;
        bit non, done;
        logic [15:0] rem;
        logic [7:0] ptr;
    } vec_t;
    vec_t vt [13];

    initial begin
        int done_cnt;
        bit lp;
        logic [15:0] len;

        rst = 1; play = 0; pause = 0; stop = 0; loop_en = 0; preview_req = 0; preview_addr = '0;
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[0] = 24'h000354;
        rom[1] = 24'h000037;
        @(negedge clk_1ms);

        // Basic play-through: countdown, one note, end marker
        vt[0]  = '{1,0,0,0,0, 3'd0, 0, 0, 16'd0, 8'd0};
        vt[1]  = '{0,1,0,0,0, 3'd1, 0, 0, 16'd0, 8'd0};
        vt[2]  = '{0,0,0,0,0, 3'd1, 0, 0, 16'd0, 8'd0};
        vt[3]  = '{0,0,0,0,0, 3'd1, 0, 0, 16'd0, 8'd0};
        vt[4]  = '{0,0,0,0,0, 3'd1, 0, 0, 16'd0, 8'd0};
        vt[5]  = '{0,0,0,0,0, 3'd1, 0, 0, 16'd0, 8'd0};
        vt[6]  = '{0,0,0,0,0, 3'd2, 0, 0, 16'd0, 8'd0};
        vt[7]  = '{0,0,0,0,0, 3'd3, 1, 0, 16'd3, 8'd0};
        vt[8]  = '{0,0,0,0,0, 3'd3, 1, 0, 16'd2, 8'd0};
        vt[9]  = '{0,0,0,0,0, 3'd3, 1, 0, 16'd1, 8'd0};
        vt[10] = '{0,0,0,0,0, 3'd2, 0, 0, 16'd0, 8'd1};
        vt[11] = '{0,0,0,0,0, 3'd5, 0, 1, 16'd0, 8'd1};
        vt[12] = '{0,0,0,0,0, 3'd5, 0, 0, 16'd0, 8'd1};
        for (int i = 0; i < 13; i++) begin
            tick(vt[i].rst, vt[i].play, vt[i].pause, vt[i].stop, vt[i].loop_en, 0, 0);
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].st));
            chk($sformatf("vec%0d_note_on", i), 32'(note_on), 32'(vt[i].non));
            chk($sformatf("vec%0d_song_done", i), 32'(song_done), 32'(vt[i].done));
            chk($sformatf("vec%0d_remaining", i), 32'(remaining), 32'(vt[i].rem));
            chk($sformatf("vec%0d_ptr", i), 32'(note_pointer), 32'(vt[i].ptr));
        end
        chk("latched_note", 32'(cur_note), 32'd5);
        chk("latched_octave", 32'(cur_octave), 32'd4);

        // Looping: end marker sends pointer back to 0 via an extra LOAD
        done_cnt = 0;
        play_to_load(1);
        for (int i = 0; i < 4; i++) begin tick(0, 0, 0, 0, 1, 0, 0); done_cnt += int'(song_done); end
        chk("loop_load_ptr1", 32'(note_pointer), 32'd1);
        tick(0, 0, 0, 0, 1, 0, 0);
        chk("loop_back_state", 32'(state), 32'd2);
        chk("loop_back_ptr", 32'(note_pointer), 32'd0);
        tick(0, 0, 0, 0, 1, 0, 0);
        chk("loop_replay_rem", 32'(remaining), 32'd3);
        chk("loop_replay_state", 32'(state), 32'd3);
        for (int i = 0; i < 20; i++) begin tick(0, 0, 0, 0, 1, 0, 0); done_cnt += int'(song_done); end
        chk("loop_no_song_done", 32'(done_cnt), 32'd0);

        // Pause with remaining=2, hold, then resume
        play_to_load(0);
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("pre_pause_rem", 32'(remaining), 32'd2);
        tick(0, 0, 1, 0, 0, 0, 0);
        chk("paused_state", 32'(state), 32'd4);
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 0, 0, 0, 0, 0);
            chk("paused_rem_hold", 32'(remaining), 32'd2);
            chk("paused_note_off", 32'(note_on), 32'd0);
        end
        tick(0, 1, 0, 0, 0, 0, 0);
        chk("resume_state", 32'(state), 32'd3);
        chk("resume_rem", 32'(remaining), 32'd2);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("resume_rem1", 32'(remaining), 32'd1);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("resume_load", 32'(state), 32'd2);

        // pause and stop together: stop wins
        play_to_load(0);
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 1, 0, 0, 0);
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_ptr", 32'(note_pointer), 32'd0);
        chk("stop_note_on", 32'(note_on), 32'd0);

        // Preview held across LOAD is deferred one cycle
        play_to_load(0);
        tick(0, 0, 0, 0, 0, 1, 1);
        chk("load_rom_addr", 32'(last_rom_addr), 32'd0);
        chk("no_grant_in_load", 32'(preview_valid), 32'd0);
        tick(0, 0, 0, 0, 0, 1, 1);
        chk("deferred_valid", 32'(preview_valid), 32'd1);
        chk("deferred_data", 32'(preview_data), 32'h000037);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("valid_pulse_end", 32'(preview_valid), 32'd0);

        // Reset mid-PLAY with a pending preview
        tick(1, 0, 0, 0, 0, 1, 1);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_fields", {cur_note, cur_octave, remaining, 8'(note_pointer)}, 32'd0);
        chk("rst_pdata", 32'(preview_data), 32'd0);
        chk("rst_pvalid", 32'(preview_valid), 32'd0);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("rst_pvalid_after", 32'(preview_valid), 32'd0);

        // Randomized score and transport traffic against the model
        for (int i = 0; i < 256; i++) begin
            len = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
            rom[i] = {len, 4'($urandom), 4'($urandom)};
        end
        lp = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) lp = 1'($urandom);
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 14) == 0, $urandom_range(0, 59) == 0,
                 lp, 1'($urandom), int'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
